// File: rtl/inv_sqrt_arbiter_if.sv
// Bundle of request/response and unit-side signals shared by the
// inverse-square-root arbiter and whatever drives it.
interface inv_sqrt_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int FP_W    = 32
);
    logic [NUM_REQ-1:0]           req_valid_in;
    logic [NUM_REQ-1:0][FP_W-1:0] req_a_in;
    logic [NUM_REQ-1:0]           req_ready_out;
    logic [NUM_REQ-1:0]           resp_valid_out;
    logic [FP_W-1:0]              resp_res_out;
    logic [FP_W-1:0]              sqrt_a_out;
    logic                         sqrt_valid_out;
    logic [FP_W-1:0]              sqrt_res_in;
    logic                         sqrt_valid_in;
    logic                         sqrt_ready_in;

    // Arbiter side
    modport slave (
        input  req_valid_in, req_a_in, sqrt_res_in, sqrt_valid_in, sqrt_ready_in,
        output req_ready_out, resp_valid_out, resp_res_out, sqrt_a_out, sqrt_valid_out
    );

    // Requesters plus unit side
    modport master (
        output req_valid_in, req_a_in, sqrt_res_in, sqrt_valid_in, sqrt_ready_in,
        input  req_ready_out, resp_valid_out, resp_res_out, sqrt_a_out, sqrt_valid_out
    );
endinterface

// File: rtl/inv_sqrt_arbiter.sv
// Round-robin arbiter/sequencer sharing one non-pipelined inverse-sqrt unit
// between NUM_REQ requesters, with a watchdog on the unit.
//
// state | meaning
// IDLE  | waiting for a request while the unit reports ready
// ISSUE | start pulse and accept pulse visible for one cycle
// WAIT  | waiting for the unit to go busy and then report done
// RESP  | one-cycle result pulse to the granted requester
module inv_sqrt_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int FP_W           = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    inv_sqrt_arbiter_if.slave   bus,
    output logic                busy_out,
    output logic                timeout_err_out
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] next_grant;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             seen_busy;
    logic [WD_W-1:0]  wd_cnt;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        found      = 1'b0;
        next_grant = last_grant;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && bus.req_valid_in[cand]) begin
                found      = 1'b1;
                next_grant = cand;
            end
        end
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state               <= IDLE;
            grant               <= '0;
            last_grant          <= IDX_W'(NUM_REQ - 1);
            seen_busy           <= 1'b0;
            wd_cnt              <= '0;
            busy_out            <= 1'b0;
            timeout_err_out     <= 1'b0;
            bus.req_ready_out   <= '0;
            bus.resp_valid_out  <= '0;
            bus.resp_res_out    <= '0;
            bus.sqrt_a_out      <= '0;
            bus.sqrt_valid_out  <= 1'b0;
        end else begin
            bus.req_ready_out  <= '0;
            bus.resp_valid_out <= '0;
            bus.sqrt_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    bus.resp_res_out <= '0;
                    if (found && bus.sqrt_ready_in) begin
                        grant              <= next_grant;
                        bus.sqrt_a_out     <= bus.req_a_in[next_grant];
                        bus.sqrt_valid_out <= 1'b1;
                        bus.req_ready_out  <= NUM_REQ'(1) << next_grant;
                        busy_out           <= 1'b1;
                        state              <= ISSUE;
                    end
                end
                ISSUE: begin
                    seen_busy <= 1'b0;
                    wd_cnt    <= WD_W'(TIMEOUT_CYCLES - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    // A done level left over from the previous op is only
                    // trusted once the unit has been seen busy for this op.
                    if (!bus.sqrt_ready_in)
                        seen_busy <= 1'b1;
                    if (seen_busy && bus.sqrt_valid_in && bus.sqrt_ready_in) begin
                        bus.resp_valid_out <= NUM_REQ'(1) << grant;
                        bus.resp_res_out   <= bus.sqrt_res_in;
                        state              <= RESP;
                    end else if (wd_cnt == '0) begin
                        timeout_err_out    <= 1'b1;
                        bus.resp_valid_out <= NUM_REQ'(1) << grant;
                        bus.resp_res_out   <= '0;
                        state              <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                RESP: begin
                    bus.resp_res_out <= '0;
                    last_grant       <= grant;
                    busy_out         <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
